// File: rtl/spi_calc_pkg.sv
// Shared constants and FSM state type for the SPI frame receiver.
package spi_calc_pkg;
   localparam int SPI_FRAME_BITS = 48;
   localparam int SPI_WORD_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } state_e;
endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous input, with level and edge pulses.
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~prev_q;
   assign fall  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame receiver: shifts a 3-operand frame and presents it with a valid/ready handshake.
// Optional err_cnt output is enabled by defining SPI_FRAME_ERR_CNT_EN.
module spi_frame_ctrl
   import spi_calc_pkg::*;
#(
   parameter int FRAME_BITS  = SPI_FRAME_BITS,
   parameter int WORD_W      = SPI_WORD_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              master_clk,
   input  logic              master_chip_select,
   input  logic              master_data,
   output logic [WORD_W-1:0] op_a,
   output logic [WORD_W-1:0] op_b,
   output logic [WORD_W-1:0] op_c,
   output logic              op_valid,
   input  logic              op_ready,
   output logic              frame_err,
   output logic              busy
`ifdef SPI_FRAME_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);
   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic mclk_lvl_unused, mclk_rise, mclk_fall_unused;
   logic cs_lvl_unused, cs_rise, cs_fall;
   logic data_lvl, data_rise_unused, data_fall_unused;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mclk (
      .clk(clk), .rst_n(rst_n), .async_in(master_clk),
      .level(mclk_lvl_unused), .rise(mclk_rise), .fall(mclk_fall_unused));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .async_in(master_chip_select),
      .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .rst_n(rst_n), .async_in(master_data),
      .level(data_lvl), .rise(data_rise_unused), .fall(data_fall_unused));

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WORD_W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
   logic                  op_valid_q, op_valid_d;
   logic                  frame_err_q, frame_err_d;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_c_d      = op_c_q;
      op_valid_d  = op_valid_q;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_rise) begin
               state_d = SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (mclk_rise) begin
               sr_d = {sr_q[FRAME_BITS-2:0], data_lvl};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            if (cs_fall) state_d = CHECK;
         end
         CHECK: begin
            if (cnt_q == CNT_FULL) begin
               op_a_d     = sr_q[3*WORD_W-1 -: WORD_W];
               op_b_d     = sr_q[2*WORD_W-1 -: WORD_W];
               op_c_d     = sr_q[WORD_W-1:0];
               op_valid_d = 1'b1;
               state_d    = HOLD;
            end else begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end
         end
         HOLD: begin
            // A frame started while results are pending is dropped, not shifted.
            if (cs_rise) frame_err_d = 1'b1;
            if (op_valid_q && op_ready) begin
               op_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_c_q      <= '0;
         op_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_c_q      <= op_c_d;
         op_valid_q  <= op_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign op_c      = op_c_q;
   assign op_valid  = op_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q == SHIFT);

`ifdef SPI_FRAME_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // A handshake clears the count even if an error pulse lands on the same cycle.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (op_valid_q && op_ready)
         err_cnt_d = '0;
      else if (frame_err_q && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl: expected frame outcomes are queued at stimulus time
// and matched against op_valid / frame_err pulses.
module tb_spi_frame_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        master_clk, master_chip_select, master_data;
   logic [15:0] op_a, op_b, op_c;
   logic        op_valid, op_ready, frame_err, busy;
`ifdef SPI_FRAME_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   spi_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .master_clk(master_clk), .master_chip_select(master_chip_select),
      .master_data(master_data),
      .op_a(op_a), .op_b(op_b), .op_c(op_c),
      .op_valid(op_valid), .op_ready(op_ready),
      .frame_err(frame_err), .busy(busy)
`ifdef SPI_FRAME_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [15:0] a, b, c;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   rdy_always = 1'b1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_good(input logic [47:0] d);
      exp_t e;
      e.is_err = 1'b0;
      e.a = d[47:32]; e.b = d[31:16]; e.c = d[15:0];
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.a = '0; e.b = '0; e.c = '0;
      sb.push_back(e);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Bit-bangs bits hi down to hi-n+1 of d, MSB first.
   task automatic shift_bits(input logic [63:0] d, input int hi, input int n);
      for (int i = hi; i > hi - n; i--) begin
         master_data = d[i];
         wait_clk(4);
         master_clk = 1'b1;
         wait_clk(4);
         master_clk = 1'b0;
      end
   endtask

   task automatic frame(input logic [63:0] d, input int n, input bit exp_busy);
      master_chip_select = 1'b1;
      wait_clk(4);
      shift_bits(d, n - 1, n);
      chk("busy_during_frame", {63'd0, busy}, {63'd0, exp_busy});
      wait_clk(4);
      master_chip_select = 1'b0;
      wait_clk(20);
      chk("busy_after_frame", {63'd0, busy}, 64'd0);
      $display("frame n=%0d data=0x%0h op_a=%h op_b=%h op_c=%h op_valid=%b", n, d, op_a, op_b, op_c, op_valid);
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   exp_t e_mon;
   bit   ov_prev = 1'b0;
   int   ov_len  = 0;
   always @(negedge clk) begin
      if (frame_err) begin
         chk("sb_has_entry_for_err", sb.size(), 1 + (sb.size() > 1 ? sb.size() - 1 : 0));
         if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            chk("outcome_is_err", 64'd1, {63'd0, e_mon.is_err});
         end
      end
      if (op_valid && !ov_prev) begin
         chk("sb_has_entry_for_valid", sb.size(), 1 + (sb.size() > 1 ? sb.size() - 1 : 0));
         if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            chk("outcome_is_good", 64'd0, {63'd0, e_mon.is_err});
            if (!e_mon.is_err) begin
               chk("op_a", op_a, e_mon.a);
               chk("op_b", op_b, e_mon.b);
               chk("op_c", op_c, e_mon.c);
            end
         end
      end
      if (op_valid) ov_len++;
      else begin
         if (ov_prev && rdy_always) chk("op_valid_len", ov_len, 1);
         ov_len = 0;
      end
      ov_prev = op_valid;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      master_clk = 1'b0; master_chip_select = 1'b0; master_data = 1'b0;
      op_ready = 1'b1;
      wait_clk(5);
      #1;
      chk("rst_op_valid", {63'd0, op_valid}, 64'd0);
      chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ops", {op_a, op_b, op_c}, 64'd0);
      rst_n = 1'b1;
      wait_clk(5);

      // Good frame, consumer always ready.
      push_good(48'h1234_ABCD_0F0F);
      frame(64'h1234_ABCD_0F0F, 48, 1'b1);
      chk("good_ops_kept", {op_a, op_b, op_c}, 64'h1234_ABCD_0F0F);
      chk("good_valid_done", {63'd0, op_valid}, 64'd0);

      // Short frame: error, ops untouched.
      push_err();
      frame(64'h0000_7FFF_5555_AAAA, 47, 1'b1);
      chk("short_ops_kept", {op_a, op_b, op_c}, 64'h1234_ABCD_0F0F);
      chk("short_no_valid", {63'd0, op_valid}, 64'd0);

      // Long frame: error.
      push_err();
      frame(64'h0003_1111_2222_3333, 50, 1'b1);
      chk("long_ops_kept", {op_a, op_b, op_c}, 64'h1234_ABCD_0F0F);
      chk("long_no_valid", {63'd0, op_valid}, 64'd0);

      // Consumer stalled: second frame is dropped while holding the first.
      rdy_always = 1'b0;
      op_ready   = 1'b0;
      push_good(48'hAAAA_5555_1111);
      frame(64'hAAAA_5555_1111, 48, 1'b1);
      chk("hold_valid_high", {63'd0, op_valid}, 64'd1);
      push_err();
      frame(64'h0BAD_0BAD_0BAD, 48, 1'b0);
      chk("hold_ops_first", {op_a, op_b, op_c}, 64'hAAAA_5555_1111);
      chk("hold_valid_still", {63'd0, op_valid}, 64'd1);
      op_ready = 1'b1;
      wait_clk(3);
      chk("hold_released", {63'd0, op_valid}, 64'd0);
      rdy_always = 1'b1;
      push_good(48'hC0DE_FACE_9876);
      frame(64'hC0DE_FACE_9876, 48, 1'b1);
      chk("third_ops", {op_a, op_b, op_c}, 64'hC0DE_FACE_9876);

      // Reset in the middle of a frame.
      master_chip_select = 1'b1;
      wait_clk(4);
      shift_bits(64'h5A5A_C3C3_F00D, 47, 20);
      chk("busy_before_reset", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_ops", {op_a, op_b, op_c}, 64'd0);
      chk("midrst_valid", {63'd0, op_valid}, 64'd0);
      chk("midrst_err", {63'd0, frame_err}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      wait_clk(3);
      master_chip_select = 1'b0;
      master_clk = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);
      push_good(48'h5A5A_C3C3_F00D);
      frame(64'h5A5A_C3C3_F00D, 48, 1'b1);
      chk("post_rst_ops", {op_a, op_b, op_c}, 64'h5A5A_C3C3_F00D);

`ifdef SPI_FRAME_ERR_CNT_EN
      for (int k = 0; k < 300; k++) begin
         push_err();
         master_chip_select = 1'b1;
         wait_clk(4);
         shift_bits(64'h2, 1, 2);
         wait_clk(4);
         master_chip_select = 1'b0;
         wait_clk(12);
      end
      chk("err_cnt_sat", {56'd0, err_cnt}, 64'd255);
      push_good(48'h0102_0304_0506);
      frame(64'h0102_0304_0506, 48, 1'b1);
      chk("err_cnt_cleared", {56'd0, err_cnt}, 64'd0);
`endif

      wait_clk(10);
      chk("sb_drained", sb.size(), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 48, meaning bits per valid frame.
REQ-002 SHALL have parameter WORD_W, default 16, meaning operand width; FRAME_BITS = 3*WORD_W.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth, minimum 2.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port master_clk, input, 1, SPI serial clock from the master, asynchronous to clk.
REQ-007 SHALL have port master_chip_select, input, 1, active-high frame enable, asynchronous.
REQ-008 SHALL have port master_data, input, 1, serial data, MSB first, asynchronous.
REQ-009 SHALL have ports op_a, op_b and op_c, output, WORD_W each, operands of the last good frame.
REQ-010 SHALL have port op_valid, output, 1, meaning op_a/op_b/op_c are valid.
REQ-011 SHALL have port op_ready, input, 1, consumer acceptance.
REQ-012 SHALL have port frame_err, output, 1, a one-cycle pulse on a bad or dropped frame.
REQ-013 SHALL have port busy, output, 1, high while a frame is being shifted in.

Function
REQ-014 SHALL pass master_clk, master_chip_select and master_data through SYNC_STAGES flops each before use.
REQ-015 SHALL detect a master_clk rising edge as synced sample 1 with previous sample 0, and sample the synced master_data on that cycle.
REQ-016 SHALL implement the states IDLE, SHIFT, CHECK and HOLD.
REQ-017 SHALL go from IDLE to SHIFT on the synced chip-select rising edge, clearing the shift register and the bit counter.
REQ-018 SHALL, in SHIFT, shift left on each detected edge with the new bit into bit 0, incrementing a saturating bit counter of width clog2(FRAME_BITS+2).
REQ-019 SHALL go from SHIFT to CHECK on the synced chip-select falling edge.
REQ-020 SHALL, in CHECK, take exactly one cycle, then behave as follows:
  - count == FRAME_BITS: load op_a = sr[47:32], op_b = sr[31:16], op_c = sr[15:0], set op_valid, and go to HOLD.
  - any other count (short frame, or overflow above FRAME_BITS): pulse frame_err and go to IDLE.
REQ-021 SHALL, in HOLD, keep op_* and op_valid stable until op_valid && op_ready, then clear op_valid and go to IDLE on the next cycle.
REQ-022 SHALL accept op_ready already high on entry to HOLD, so that op_valid lasts exactly one cycle.
REQ-023 SHALL, on a chip-select rising edge while in HOLD, ignore the frame (no shifting), pulse frame_err once, and leave op_* untouched.
REQ-024 SHALL drive busy high exactly when the state is SHIFT.
REQ-025 SHALL have latency from the synced chip-select fall to op_valid of 2 clk cycles.
REQ-026 SHALL NOT change op_* outside the CHECK-to-HOLD load.

Reset
REQ-027 SHALL, on rst_n low, immediately set: state IDLE, the shift register, counter and synchronizer flops to 0, op_a/op_b/op_c = 0, op_valid = 0, frame_err = 0, busy = 0.
REQ-028 SHALL, on reset during SHIFT or HOLD, discard the partial or pending frame; after release it waits for a fresh chip-select rising edge.

Configuration
REQ-029 SHALL, when SPI_FRAME_ERR_CNT_EN is defined, add output err_cnt[7:0]:
  - it increments on every frame_err pulse and saturates at 255;
  - it resets to 0;
  - it clears on an op_valid && op_ready handshake.
REQ-030 SHALL, when SPI_FRAME_ERR_CNT_EN is undefined, omit the err_cnt port and its logic, with all other behaviour identical.

Structure
REQ-031 SHALL take FRAME_BITS, WORD_W and the state enum (IDLE, SHIFT, CHECK, HOLD) from shared package spi_calc_pkg.
REQ-032 SHALL use one sub-module, spi_sync: a SYNC_STAGES-deep synchronizer that outputs the synced level, a rise pulse and a fall pulse, instantiated per input.

Verification
REQ-033 SHALL cover: 48-bit frame 0x1234_ABCD_0F0F with op_ready=1 -> op_a=0x1234, op_b=0xABCD, op_c=0x0F0F; op_valid for 1 cycle; frame_err=0.
REQ-034 SHALL cover: 47-bit frame -> frame_err pulses once, op_valid stays 0, op_* keep their previous values.
REQ-035 SHALL cover: 50-bit frame -> frame_err pulse, no op_valid.
REQ-036 SHALL cover: op_ready=0, good frame, then a second frame -> op_* hold the first frame, frame_err pulses, and after op_ready=1 a third frame is accepted.
REQ-037 SHALL cover: rst_n low at bit 20 of a frame -> all outputs 0 at once; after release a full good frame loads correctly.
REQ-038 SHALL cover: with SPI_FRAME_ERR_CNT_EN defined, 300 short frames -> err_cnt=255; a good frame plus handshake -> err_cnt=0.
